exc_vector_seq: RTL and testbench

- Exception sequencer for the multicycle CPU datapath; sits directly upstream of the memory source-address mux.
- On overflow, invalid opcode or divide-by-zero it:
  - drives the mux select to the matching vector byte address (253/254/255);
  - waits for memory read latency and captures the handler byte;
  - commits PC = zero-extended byte and EPC = faulting PC - 4.
- The control unit hands memory-address ownership to this block while busy=1.

---
 rtl/exc_vector_seq.sv | 144 ++++++++++++++
 tb/tb_exc_vector_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_seq.sv
// exc_vector_seq: exception sequencer for the multicycle CPU datapath.
// On an exception request it points the memory address mux at the vector
// byte (253/254/255), waits MEM_WAIT edges for the read, then commits
// PC = handler byte and EPC = faulting PC - 4 with one-cycle strobes.
// Optional build macro EXC_CAUSE_REG_EN adds a sticky cause register
// (cause_out) with an idle-time clear input (cause_clr).
module exc_vector_seq #(
  parameter int         MEM_WAIT = 2,
  parameter logic [2:0] SEL_IDLE = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  src_addr_sel,
  output logic        mem_wr,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic        pc_wr,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic        done
`ifdef EXC_CAUSE_REG_EN
  ,
  input  logic        cause_clr,
  output logic [1:0]  cause_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Wait counter is loaded with MEM_WAIT-1 so the byte is captured on edge MEM_WAIT.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [2:0]  sel_reg, sel_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] epc_reg, epc_next;

  logic        trig;
  logic [2:0]  vec_code;

  // Only the low byte of memory data is the handler address.
  logic        unused_hi;
  assign unused_hi = ^mem_data_in[31:8];

  // Request decode with fixed priority: opcode > overflow > div0.
  always_comb begin
    trig     = exc_opcode | exc_overflow | exc_div0;
    vec_code = 3'b011;
    if (exc_opcode) begin
      vec_code = 3'b001;
    end else if (exc_overflow) begin
      vec_code = 3'b010;
    end
  end

  // Next-state logic: trigger in IDLE, count down the read latency, commit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (trig) begin
          state_next = ST_WAIT;
          sel_next   = vec_code;
          epc_next   = pc_in - 32'd4;
          cnt_next   = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          pc_next    = {24'b0, mem_data_in[7:0]};
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_next = ST_IDLE;
        sel_next   = SEL_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        sel_next   = SEL_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 3'd0;
      sel_reg   <= SEL_IDLE;
      pc_reg    <= 32'd0;
      epc_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      pc_reg    <= pc_next;
      epc_reg   <= epc_next;
    end
  end

  assign src_addr_sel = sel_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign pc_wr        = (state_reg == ST_COMMIT);
  assign epc_wr       = (state_reg == ST_COMMIT);
  assign done         = (state_reg == ST_COMMIT);
  assign mem_wr       = 1'b0;
  assign pc_out       = pc_reg;
  assign epc_out      = epc_reg;

`ifdef EXC_CAUSE_REG_EN
  logic [1:0] cause_reg;

  // Sticky cause: loaded on trigger, cleared only by reset or an idle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cause_reg <= 2'd0;
    end else if (state_reg == ST_IDLE && trig) begin
      cause_reg <= vec_code[1:0];
    end else if (state_reg == ST_IDLE && cause_clr) begin
      cause_reg <= 2'd0;
    end
  end

  assign cause_out = cause_reg;
`endif

endmodule

// File: tb/tb_exc_vector_seq.sv
// Bench for exc_vector_seq: two instances (MEM_WAIT=2 and MEM_WAIT=1) share
// the stimulus; a transaction-level model predicts every output each cycle,
// and directed literal checks pin the scenarios of interest.
module tb_exc_vector_seq;

  localparam int MW0 = 2;
  localparam int MW1 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in, mem_data_in;
  logic        cause_clr;

  logic [2:0]  sel_o   [2];
  logic        memwr_o [2];
  logic        busy_o  [2];
  logic [31:0] pc_o    [2];
  logic        pcwr_o  [2];
  logic [31:0] epc_o   [2];
  logic        epcwr_o [2];
  logic        done_o  [2];
`ifdef EXC_CAUSE_REG_EN
  logic [1:0]  cause_o [2];
`endif

  // Model state: one in-flight transaction per instance, tracked by the
  // number of edges since its trigger edge.
  bit          m_act   [2];
  int          m_phase [2];
  logic [2:0]  m_code  [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_epc   [2];
  logic [1:0]  m_cause [2];

  int vec_cnt = 0;
  int err_cnt = 0;
  int pcwr_cnt [2];
  int snap0, snap1;

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_WAIT(MW0), .SEL_IDLE(3'b000)) dut0 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .src_addr_sel(sel_o[0]), .mem_wr(memwr_o[0]), .busy(busy_o[0]),
    .pc_out(pc_o[0]), .pc_wr(pcwr_o[0]), .epc_out(epc_o[0]),
    .epc_wr(epcwr_o[0]), .done(done_o[0])
`ifdef EXC_CAUSE_REG_EN
    , .cause_clr(cause_clr), .cause_out(cause_o[0])
`endif
  );

  exc_vector_seq #(.MEM_WAIT(MW1), .SEL_IDLE(3'b000)) dut1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem_data_in),
    .src_addr_sel(sel_o[1]), .mem_wr(memwr_o[1]), .busy(busy_o[1]),
    .pc_out(pc_o[1]), .pc_wr(pcwr_o[1]), .epc_out(epc_o[1]),
    .epc_wr(epcwr_o[1]), .done(done_o[1])
`ifdef EXC_CAUSE_REG_EN
    , .cause_clr(cause_clr), .cause_out(cause_o[1])
`endif
  );

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the rising edge,
  // then compare all outputs of both instances on the falling edge.
  task automatic step();
    int mw;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mw = (i == 0) ? MW0 : MW1;
      if (reset) begin
        m_act[i] = 1'b0; m_pc[i] = 32'd0; m_epc[i] = 32'd0; m_cause[i] = 2'd0;
      end else if (m_act[i]) begin
        m_phase[i]++;
        if (m_phase[i] == mw) m_pc[i] = {24'd0, mem_data_in[7:0]};
        if (m_phase[i] > mw) m_act[i] = 1'b0;
      end else if (exc_opcode || exc_overflow || exc_div0) begin
        m_act[i]   = 1'b1;
        m_phase[i] = 0;
        m_code[i]  = exc_opcode ? 3'd1 : (exc_overflow ? 3'd2 : 3'd3);
        m_epc[i]   = pc_in - 32'd4;
        m_cause[i] = m_code[i][1:0];
      end else if (cause_clr) begin
        m_cause[i] = 2'd0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic strobe;
      mw = (i == 0) ? MW0 : MW1;
      strobe = m_act[i] && (m_phase[i] == mw);
      cmp("busy",   i, {31'd0, busy_o[i]},  {31'd0, m_act[i]});
      cmp("sel",    i, {29'd0, sel_o[i]},   m_act[i] ? {29'd0, m_code[i]} : 32'd0);
      cmp("pc_wr",  i, {31'd0, pcwr_o[i]},  {31'd0, strobe});
      cmp("epc_wr", i, {31'd0, epcwr_o[i]}, {31'd0, strobe});
      cmp("done",   i, {31'd0, done_o[i]},  {31'd0, strobe});
      cmp("mem_wr", i, {31'd0, memwr_o[i]}, 32'd0);
      cmp("pc_out", i, pc_o[i],  m_pc[i]);
      cmp("epc_out", i, epc_o[i], m_epc[i]);
`ifdef EXC_CAUSE_REG_EN
      cmp("cause",  i, {30'd0, cause_o[i]}, {30'd0, m_cause[i]});
`endif
      if (pcwr_o[i] === 1'b1) pcwr_cnt[i]++;
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    pcwr_cnt[0] = 0; pcwr_cnt[1] = 0;
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    m_phase[0] = 0; m_phase[1] = 0;
    m_code[0] = 3'd0; m_code[1] = 3'd0;
    reset = 1'b1; exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = 32'd0; mem_data_in = 32'd0; cause_clr = 1'b0;
    steps(2);
    cmp("rst_busy", 0, {31'd0, busy_o[0]}, 32'd0);
    cmp("rst_sel",  0, {29'd0, sel_o[0]},  32'd0);
    cmp("rst_pc",   0, pc_o[0],  32'd0);
    cmp("rst_epc",  0, epc_o[0], 32'd0);
    reset = 1'b0;
    step();

    // Reset during the first WAIT cycle aborts with no strobe.
    pc_in = 32'h0000_0200; mem_data_in = 32'h0000_0077; exc_opcode = 1'b1;
    step();
    cmp("abort_sel_trig", 0, {29'd0, sel_o[0]}, 32'd1);
    exc_opcode = 1'b0; reset = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      cmp("abort_busy", i, {31'd0, busy_o[i]}, 32'd0);
      cmp("abort_sel",  i, {29'd0, sel_o[i]},  32'd0);
      cmp("abort_pc",   i, pc_o[i],  32'd0);
      cmp("abort_epc",  i, epc_o[i], 32'd0);
    end
    reset = 1'b0;
    steps(3);
    cmp("abort_no_pcwr", 0, pcwr_cnt[0], 32'd0);
    cmp("abort_no_pcwr", 1, pcwr_cnt[1], 32'd0);

    // Overflow with MEM_WAIT=2: strobe only after edge 2.
    pc_in = 32'h0000_0104; mem_data_in = 32'h1234_56A5; exc_overflow = 1'b1;
    step();
    cmp("ovf_sel_e0",  0, {29'd0, sel_o[0]}, 32'd2);
    cmp("ovf_pcwr_e0", 0, {31'd0, pcwr_o[0]}, 32'd0);
`ifdef EXC_CAUSE_REG_EN
    cmp("ovf_cause", 0, {30'd0, cause_o[0]}, 32'd2);
`endif
    exc_overflow = 1'b0;
    step();
    cmp("ovf_pcwr_e1", 0, {31'd0, pcwr_o[0]}, 32'd0);
    step();
    cmp("ovf_pcwr_e2",  0, {31'd0, pcwr_o[0]},  32'd1);
    cmp("ovf_epcwr_e2", 0, {31'd0, epcwr_o[0]}, 32'd1);
    cmp("ovf_done_e2",  0, {31'd0, done_o[0]},  32'd1);
    cmp("ovf_pc",  0, pc_o[0],  32'h0000_00A5);
    cmp("ovf_epc", 0, epc_o[0], 32'h0000_0100);
    step();
    cmp("ovf_sel_e3",  0, {29'd0, sel_o[0]},  32'd0);
    cmp("ovf_busy_e3", 0, {31'd0, busy_o[0]}, 32'd0);
    cmp("ovf_pc_hold", 0, pc_o[0], 32'h0000_00A5);

    // Priority, then a div0 pulse during WAIT that must be ignored.
    snap0 = pcwr_cnt[0]; snap1 = pcwr_cnt[1];
    exc_opcode = 1'b1; exc_overflow = 1'b1; exc_div0 = 1'b1;
    step();
    cmp("prio_sel", 0, {29'd0, sel_o[0]}, 32'd1);
`ifdef EXC_CAUSE_REG_EN
    cmp("prio_cause", 0, {30'd0, cause_o[0]}, 32'd1);
`endif
    exc_opcode = 1'b0; exc_overflow = 1'b0;
    step();
    cmp("ign_sel_e1", 0, {29'd0, sel_o[0]}, 32'd1);
    exc_div0 = 1'b0;
    step();
    cmp("ign_sel_e2", 0, {29'd0, sel_o[0]}, 32'd1);
    step();
    cmp("ign_idle_e3", 0, {31'd0, busy_o[0]}, 32'd0);
    step();
    cmp("ign_idle_e4", 0, {31'd0, busy_o[0]}, 32'd0);
    step();
    cmp("ign_one_pcwr", 0, pcwr_cnt[0] - snap0, 32'd1);
    cmp("ign_one_pcwr", 1, pcwr_cnt[1] - snap1, 32'd1);

    // Back-to-back: div0 held high for nine edges.
    snap0 = pcwr_cnt[0]; snap1 = pcwr_cnt[1];
    pc_in = 32'h0000_0040; mem_data_in = 32'h0000_003C; exc_div0 = 1'b1;
    steps(9);
    cmp("b2b_pulses", 1, pcwr_cnt[1] - snap1, 32'd3);
    cmp("b2b_pulses", 0, pcwr_cnt[0] - snap0, 32'd2);
    cmp("b2b_pc", 1, pc_o[1], 32'h0000_003C);
    exc_div0 = 1'b0;
    steps(4);

    // PC wrap: pc_in = 0 gives EPC = 0xFFFFFFFC.
    pc_in = 32'd0; mem_data_in = 32'h0000_0011; exc_opcode = 1'b1;
    step();
    exc_opcode = 1'b0;
    cmp("wrap_memwr", 0, {31'd0, memwr_o[0]}, 32'd0);
    cmp("wrap_epc",   0, epc_o[0], 32'hFFFF_FFFC);
    cmp("wrap_epc",   1, epc_o[1], 32'hFFFF_FFFC);
    steps(4);
    cmp("wrap_pc", 0, pc_o[0], 32'h0000_0011);

`ifdef EXC_CAUSE_REG_EN
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    cmp("cause_clr", 0, {30'd0, cause_o[0]}, 32'd0);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
